// File: rtl/set_assoc_cache.sv
// set_assoc_cache: write-back, write-allocate NUM_WAYS-way set-associative cache with tree-PLRU
// replacement. Defining CACHE_STATS_EN adds the hit_count / miss_count outputs.
module set_assoc_cache #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 4,
  parameter int NUM_WAYS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   mem_address,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [(2**S_OFFSET)-1:0]      mem_byte_enable,
  input  logic [8*(2**S_OFFSET)-1:0]    mem_wdata,
  output logic [8*(2**S_OFFSET)-1:0]    mem_rdata,
  output logic                          mem_resp,
  output logic [31:0]                   pmem_address,
  output logic                          pmem_read,
  output logic                          pmem_write,
  output logic [8*(2**S_OFFSET)-1:0]    pmem_wdata,
  input  logic [8*(2**S_OFFSET)-1:0]    pmem_rdata,
  input  logic                          pmem_resp
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count
`endif
);

  localparam int LINE_BYTES = 2 ** S_OFFSET;
  localparam int LINE_BITS  = 8 * LINE_BYTES;
  localparam int SETS       = 2 ** S_INDEX;
  localparam int TAG_W      = 32 - S_OFFSET - S_INDEX;
  localparam int WAY_W      = $clog2(NUM_WAYS);
  localparam int PLRU_W     = NUM_WAYS - 1;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_e;

  state_e state_q, state_d;

  logic [TAG_W-1:0]     tag_q  [NUM_WAYS][SETS];
  logic [LINE_BITS-1:0] data_q [NUM_WAYS][SETS];
  logic [SETS-1:0][NUM_WAYS-1:0] valid_q;
  logic [SETS-1:0][NUM_WAYS-1:0] dirty_q;
  logic [SETS-1:0][PLRU_W-1:0]   plru_q;
  logic [WAY_W-1:0]              victim_q;

  logic [S_INDEX-1:0]   index;
  logic [TAG_W-1:0]     req_tag;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic                 has_invalid;
  logic [WAY_W-1:0]     invalid_way;
  logic [WAY_W-1:0]     victim;
  logic [LINE_BITS-1:0] merged_line;
  logic                 unused_offset_bits;

  assign index              = mem_address[S_OFFSET +: S_INDEX];
  assign req_tag            = mem_address[31 -: TAG_W];
  assign unused_offset_bits = ^mem_address[S_OFFSET-1:0];

  // Tree walk from the root: each node bit selects the subtree holding the LRU side.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] tree);
    int node;
    logic [WAY_W-1:0] way;
    node = 1;
    way  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      way[WAY_W-1-l] = tree[node-1];
      node = 2 * node + int'(tree[node-1]);
    end
    return way;
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] tree,
                                                   input logic [WAY_W-1:0] way);
    int node;
    logic b;
    logic [PLRU_W-1:0] t;
    node = 1;
    t    = tree;
    for (int l = 0; l < WAY_W; l++) begin
      b         = way[WAY_W-1-l];
      t[node-1] = ~b;
      node      = 2 * node + int'(b);
    end
    return t;
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[index][w] && tag_q[w][index] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    has_invalid = 1'b0;
    invalid_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[index][w]) begin
        has_invalid = 1'b1;
        invalid_way = WAY_W'(w);
      end
    end
  end

  assign victim = has_invalid ? invalid_way : plru_victim(plru_q[index]);

  always_comb begin
    merged_line = data_q[hit_way][index];
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (mem_byte_enable[b]) merged_line[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          mem_resp  = 1'b1;
          mem_rdata = data_q[hit_way][index];
          state_d   = IDLE;
        end else if (valid_q[index][victim] && dirty_q[index][victim]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[victim_q][index], index, {S_OFFSET{1'b0}}};
        pmem_wdata   = data_q[victim_q][index];
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, index, {S_OFFSET{1'b0}}};
        if (pmem_resp) state_d = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      plru_q   <= '0;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        COMPARE: begin
          if (hit) begin
            plru_q[index] <= plru_touch(plru_q[index], hit_way);
            if (mem_write) dirty_q[index][hit_way] <= 1'b1;
          end else begin
            victim_q <= victim;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            valid_q[index][victim_q] <= 1'b1;
            dirty_q[index][victim_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: tag and data storage has no reset; valid bits gate every use of their contents.
  always_ff @(posedge clk) begin
    if (state_q == COMPARE && hit && mem_write) begin
      data_q[hit_way][index] <= merged_line;
    end
    if (state_q == FILL && pmem_resp) begin
      data_q[victim_q][index] <= pmem_rdata;
      tag_q[victim_q][index]  <= req_tag;
    end
  end

`ifdef CACHE_STATS_EN
  // refill_q marks a request that already missed, so its post-fill hit is not counted.
  logic refill_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      refill_q   <= 1'b0;
    end else begin
      if (state_q == IDLE) refill_q <= 1'b0;
      if (state_q == COMPARE) begin
        if (hit && !refill_q) begin
          hit_count <= hit_count + 32'd1;
        end else if (!hit) begin
          miss_count <= miss_count + 32'd1;
          refill_q   <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
